// File: rtl/cache_line_tester_if.sv
// Line-request bus between the cache line tester (master) and a line memory (slave).
// Handshake: the master raises o_req together with o_addr/o_wen/o_wdata and holds all of
// them stable until it samples i_ack high. The transfer happens on the rising edge where
// o_req and i_ack are both high, and a read returns i_rdata in that same cycle. i_ack
// while o_req is low has no meaning and is ignored.
interface cache_line_tester_if #(
    parameter int ADDR_W    = 64,
    parameter int LINE_BITS = 512
);
    logic                 o_req;
    logic                 i_ack;
    logic [ADDR_W-1:0]    o_addr;
    logic                 o_wen;
    logic [LINE_BITS-1:0] o_wdata;
    logic [LINE_BITS-1:0] i_rdata;

    modport master (output o_req, o_addr, o_wen, o_wdata, input i_ack, i_rdata);
    modport slave  (input o_req, o_addr, o_wen, o_wdata, output i_ack, i_rdata);
endinterface

// File: rtl/cache_line_tester.sv
// Cache-line traffic generator and checker. Writes an address-derived pattern to a
// block of consecutive lines, reads the lines back and counts the mismatching ones.
module cache_line_tester #(
    parameter int                LINE_BITS = 512,
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
    parameter int                NUM_LINES = 4,
    parameter int                INTERVAL  = 1000,
    parameter int                MODE      = 2,
    parameter logic [63:0]       SEED      = 64'h0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pass,
    output logic [15:0]         o_err_count,
    output logic [ADDR_W-1:0]   o_first_err_addr,
    output logic [2:0]          o_state,
    cache_line_tester_if.master io_line
);

    localparam int                IDX_W      = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int                CNT_W      = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_LINES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(LINE_BITS / 8);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_REQ   = 3'd2,
        S_CHECK = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_read_pass;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [15:0]           r_err_count;
    logic [ADDR_W-1:0]     r_first_err_addr;
    logic                  r_req;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wen;
    logic [LINE_BITS-1:0]  r_wdata;
    logic [LINE_BITS-1:0]  r_rdata;

    logic [ADDR_W-1:0]     w_line_addr;
    logic [LINE_BITS-1:0]  w_line_pat;

    // Lane j of the line at address a is (a + 8*j) ^ SEED, all in 64-bit arithmetic.
    function automatic logic [LINE_BITS-1:0] line_pattern(input logic [ADDR_W-1:0] a);
        logic [LINE_BITS-1:0] p;
        logic [63:0]          a64;
        a64 = 64'(a);
        p   = '0;
        for (int j = 0; j < LINE_BITS / 64; j++) begin
            p[j*64 +: 64] = (a64 + 64'(j) * 64'd8) ^ SEED;
        end
        return p;
    endfunction

    // Address and expected contents of the line selected by the current index.
    assign w_line_addr = BASE_ADDR + ADDR_W'(r_idx) * LINE_BYTES;
    assign w_line_pat  = line_pattern(w_line_addr);

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;
    assign o_state          = r_state;
    assign io_line.o_req    = r_req;
    assign io_line.o_addr   = r_addr;
    assign io_line.o_wen    = r_wen;
    assign io_line.o_wdata  = r_wdata;

    // Run sequencer: interval wait, one request at a time, compare on reads, pass/line stepping.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_cnt            <= '0;
            r_read_pass      <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_req            <= 1'b0;
            r_addr           <= BASE_ADDR;
            r_wen            <= 1'b0;
            r_wdata          <= '0;
            r_rdata          <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_err_count      <= '0;
                        r_first_err_addr <= '0;
                        r_done           <= 1'b0;
                        r_pass           <= 1'b0;
                        r_busy           <= 1'b1;
                        r_idx            <= '0;
                        r_cnt            <= '0;
                        r_read_pass      <= (MODE == 1);
                        r_state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_req   <= 1'b1;
                        r_addr  <= w_line_addr;
                        r_wen   <= ~r_read_pass;
                        // Held for reads too: it is the reference the CHECK cycle compares against.
                        r_wdata <= w_line_pat;
                        r_state <= S_REQ;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_REQ: begin
                    if (r_req && io_line.i_ack) begin
                        r_req <= 1'b0;
                        if (r_wen) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_rdata <= io_line.i_rdata;
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (r_rdata != r_wdata) begin
                        if (r_err_count != 16'hFFFF) begin
                            r_err_count <= r_err_count + 16'd1;
                        end
                        if (r_err_count == 16'd0) begin
                            r_first_err_addr <= r_addr;
                        end
                    end
                    r_state <= S_NEXT;
                end
                S_NEXT: begin
                    if (r_idx < IDX_LAST) begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_state <= S_WAIT;
                    end else if (!r_read_pass && (MODE == 2)) begin
                        r_read_pass <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= S_WAIT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_count == 16'd0);
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_tester.sv
// Bench for cache_line_tester: a write/verify instance and a read-only instance, each
// served by a behavioural line memory, checked against a request-level reference model.
module tb_cache_line_tester;

  localparam int          INTERVAL = 4;
  localparam int          NLINES   = 2;
  localparam logic [63:0] BASE     = 64'h8000_0000;
  localparam logic [63:0] SEED_RO  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [192:0] HDR_MASK = {65'h1_FFFF_FFFF_FFFF_FFFF, 128'h0};

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic         start_a[2], busy_a[2], done_a[2], pass_a[2];
  logic         req_a[2], wen_a[2], ack_a[2];
  logic [15:0]  err_a[2];
  logic [63:0]  first_a[2], addr_a[2];
  logic [127:0] wdata_a[2], rdata_a[2];
  logic [2:0]   st_a[2];

  // request records are {wen, addr, wdata}
  logic [192:0] exp_q[$];
  logic [192:0] obs_q[$];
  logic [127:0] ret_q[$];
  int           rise_q[$];
  int           hs_q[$];
  logic [127:0] mem [logic [63:0]];

  cache_line_tester_if #(.ADDR_W(64), .LINE_BITS(128)) bus_rw ();
  cache_line_tester_if #(.ADDR_W(64), .LINE_BITS(128)) bus_ro ();

  cache_line_tester #(
    .LINE_BITS(128), .ADDR_W(64), .BASE_ADDR(BASE), .NUM_LINES(NLINES),
    .INTERVAL(INTERVAL), .MODE(2), .SEED(64'h0)
  ) dut_rw (
    .clock(clock), .reset(reset), .i_start(start_a[0]), .o_busy(busy_a[0]),
    .o_done(done_a[0]), .o_pass(pass_a[0]), .o_err_count(err_a[0]),
    .o_first_err_addr(first_a[0]), .o_state(st_a[0]), .io_line(bus_rw)
  );

  cache_line_tester #(
    .LINE_BITS(128), .ADDR_W(64), .BASE_ADDR(BASE), .NUM_LINES(NLINES),
    .INTERVAL(INTERVAL), .MODE(1), .SEED(SEED_RO)
  ) dut_ro (
    .clock(clock), .reset(reset), .i_start(start_a[1]), .o_busy(busy_a[1]),
    .o_done(done_a[1]), .o_pass(pass_a[1]), .o_err_count(err_a[1]),
    .o_first_err_addr(first_a[1]), .o_state(st_a[1]), .io_line(bus_ro)
  );

  assign req_a[0] = bus_rw.o_req;   assign req_a[1] = bus_ro.o_req;
  assign wen_a[0] = bus_rw.o_wen;   assign wen_a[1] = bus_ro.o_wen;
  assign addr_a[0] = bus_rw.o_addr; assign addr_a[1] = bus_ro.o_addr;
  assign wdata_a[0] = bus_rw.o_wdata; assign wdata_a[1] = bus_ro.o_wdata;
  assign bus_rw.i_ack = ack_a[0];   assign bus_ro.i_ack = ack_a[1];
  assign bus_rw.i_rdata = rdata_a[0]; assign bus_ro.i_rdata = rdata_a[1];

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // reference pattern of a 128-bit line
  function automatic logic [127:0] pat(input logic [63:0] a, input logic [63:0] seed);
    return {(a + 64'd8) ^ seed, a ^ seed};
  endfunction

  // expected request list of one run
  task automatic build_exp(input int mode, input logic [63:0] seed);
    logic [63:0] a;
    exp_q.delete();
    if (mode != 1) for (int k = 0; k < NLINES; k++) begin
      a = BASE + 64'(16 * k);
      exp_q.push_back({1'b1, a, pat(a, seed)});
    end
    if (mode != 0) for (int k = 0; k < NLINES; k++) begin
      a = BASE + 64'(16 * k);
      exp_q.push_back({1'b0, a, 128'h0});
    end
  endtask

  // expected error count / first error address from the data the memory returned
  task automatic model_errs(input logic [63:0] seed, output int errs, output logic [63:0] first);
    logic [63:0] a;
    errs = 0;
    first = '0;
    for (int i = 0; i < obs_q.size() && i < ret_q.size(); i++) begin
      a = obs_q[i][191:128];
      if (obs_q[i][192] == 1'b0 && ret_q[i] !== pat(a, seed)) begin
        errs++;
        if (errs == 1) first = a;
      end
    end
  endtask

  // driver + line memory: starts a run and serves requests until DONE or budget
  task automatic drive_run(input int d, input int max_lat, input bit ack_tied,
                           input int flip_line, input int flip_bit, input bit poke,
                           output int t_start, output int t_done, output int viol);
    int           waited, lat, line;
    bit           in_req;
    logic [192:0] snap;
    logic [127:0] rd;
    obs_q.delete(); ret_q.delete(); rise_q.delete(); hs_q.delete();
    viol = 0; in_req = 0; waited = 0; lat = 0; t_done = -1; snap = '0;
    start_a[d] = 1'b1;
    ack_a[d] = ack_tied;
    t_start = cyc;
    @(posedge clock); #1;
    for (int n = 0; n < 3000; n++) begin
      start_a[d] = 1'b0;
      rdata_a[d] = {$urandom, $urandom, $urandom, $urandom};
      if (done_a[d] && !busy_a[d]) begin
        t_done = cyc;
        break;
      end
      if (req_a[d]) begin
        if (!in_req) begin
          in_req = 1; waited = 0;
          lat = $urandom_range(0, max_lat);
          snap = {wen_a[d], addr_a[d], wdata_a[d]};
          rise_q.push_back(cyc);
          obs_q.push_back(snap);
        end else if ({wen_a[d], addr_a[d], wdata_a[d]} !== snap) begin
          viol++;
        end
        if (ack_tied || waited == lat) begin
          ack_a[d] = 1'b1;
          in_req = 0;
          hs_q.push_back(cyc);
          if (wen_a[d]) begin
            mem[addr_a[d]] = wdata_a[d];
            rd = '0;
          end else begin
            rd = (d == 1) ? 128'h0 : (mem.exists(addr_a[d]) ? mem[addr_a[d]] : 128'h0);
            line = int'((addr_a[d] - BASE) >> 4);
            if (line == flip_line) rd[flip_bit] = ~rd[flip_bit];
            rdata_a[d] = rd;
          end
          ret_q.push_back(rd);
        end else begin
          ack_a[d] = ack_tied;
          waited++;
        end
      end else begin
        ack_a[d] = ack_tied;
        if (poke && busy_a[d]) start_a[d] = 1'b1;
      end
      @(posedge clock); #1;
    end
    ack_a[d] = 1'b0;
    start_a[d] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if ({req_a[d], busy_a[d], done_a[d], pass_a[d], wen_a[d]} !== 5'b0) begin
        n_errors++;
        $display("FAIL reset_flags[%0d]: got %b expected 00000", d,
                 {req_a[d], busy_a[d], done_a[d], pass_a[d], wen_a[d]});
      end
      n_checks++;
      if (err_a[d] !== 16'h0) begin
        n_errors++; $display("FAIL reset_err[%0d]: got %h expected 0", d, err_a[d]);
      end
      n_checks++;
      if (first_a[d] !== 64'h0) begin
        n_errors++; $display("FAIL reset_first[%0d]: got %h expected 0", d, first_a[d]);
      end
      n_checks++;
      if (addr_a[d] !== BASE) begin
        n_errors++; $display("FAIL reset_addr[%0d]: got %h expected %h", d, addr_a[d], BASE);
      end
      n_checks++;
      if (wdata_a[d] !== 128'h0) begin
        n_errors++; $display("FAIL reset_wdata[%0d]: got %h expected 0", d, wdata_a[d]);
      end
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_write_verify;
    int ts, td, v, me;
    logic [63:0] mf;
    logic [192:0] m;
    build_exp(2, 64'h0);
    drive_run(0, 4, 1'b0, -1, 0, 1'b0, ts, td, v);
    n_checks++;
    if (td < 0) begin n_errors++; $display("FAIL wv_timeout: got no done expected done"); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL wv_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      m = exp_q[i][192] ? '1 : HDR_MASK;
      n_checks++;
      if ((obs_q[i] & m) !== (exp_q[i] & m)) begin
        n_errors++; $display("FAIL wv_req[%0d]: got %h expected %h", i, obs_q[i] & m, exp_q[i] & m);
      end
    end
    model_errs(64'h0, me, mf);
    n_checks++;
    if ({pass_a[0], err_a[0], first_a[0]} !== {1'b1, 16'(me), mf}) begin
      n_errors++; $display("FAIL wv_result: got pass=%b err=%0d first=%h expected pass=1 err=%0d first=%h",
                           pass_a[0], err_a[0], first_a[0], me, mf);
    end
    n_checks++;
    if (v != 0) begin n_errors++; $display("FAIL wv_stable: got %0d changes expected 0", v); end
  endtask

  task automatic test_interval;
    int ts, td, v, exp_t;
    build_exp(2, 64'h0);
    drive_run(0, 3, 1'b0, -1, 0, 1'b0, ts, td, v);
    n_checks++;
    if (rise_q.size() != 4 || hs_q.size() != 4) begin
      n_errors++; $display("FAIL iv_count: got %0d/%0d expected 4/4", rise_q.size(), hs_q.size());
    end
    for (int i = 0; i < rise_q.size() && i < hs_q.size(); i++) begin
      // WAIT is entered one cycle after start, or after NEXT (and CHECK for reads)
      exp_t = (i == 0) ? ts + 1 + INTERVAL : hs_q[i-1] + (obs_q[i-1][192] ? 2 : 3) + INTERVAL;
      n_checks++;
      if (rise_q[i] != exp_t) begin
        n_errors++; $display("FAIL iv_rise[%0d]: got %0d expected %0d", i, rise_q[i], exp_t);
      end
    end
    if (hs_q.size() > 0) begin
      exp_t = hs_q[hs_q.size()-1] + (obs_q[obs_q.size()-1][192] ? 2 : 3);
      n_checks++;
      if (td != exp_t) begin n_errors++; $display("FAIL iv_done: got %0d expected %0d", td, exp_t); end
    end
  endtask

  task automatic test_corruption;
    int ts, td, v, me, fl, fb;
    logic [63:0] mf;
    drive_run(0, 3, 1'b0, 1, 70, 1'b0, ts, td, v);
    n_checks++;
    if ({done_a[0], pass_a[0], err_a[0], first_a[0]} !== {1'b1, 1'b0, 16'd1, 64'h8000_0010}) begin
      n_errors++; $display("FAIL corrupt_fixed: got done=%b pass=%b err=%0d first=%h expected 1 0 1 80000010",
                           done_a[0], pass_a[0], err_a[0], first_a[0]);
    end
    fl = $urandom_range(0, NLINES - 1);
    fb = $urandom_range(0, 127);
    drive_run(0, 2, 1'b0, fl, fb, 1'b0, ts, td, v);
    model_errs(64'h0, me, mf);
    n_checks++;
    if ({pass_a[0], err_a[0], first_a[0]} !== {1'b0, 16'(me), mf}) begin
      n_errors++; $display("FAIL corrupt_rand: got pass=%b err=%0d first=%h expected pass=0 err=%0d first=%h",
                           pass_a[0], err_a[0], first_a[0], me, mf);
    end
  endtask

  task automatic test_zero_wait;
    int ts, td, v, exp_len;
    drive_run(0, 0, 1'b1, -1, 0, 1'b0, ts, td, v);
    for (int i = 0; i < rise_q.size() && i < hs_q.size(); i++) begin
      n_checks++;
      if (hs_q[i] != rise_q[i]) begin
        n_errors++; $display("FAIL zw_len[%0d]: got %0d cycles expected 1", i, hs_q[i] - rise_q[i] + 1);
      end
    end
    // four requests of INTERVAL+1 cycles, two CHECK cycles, four NEXT cycles
    exp_len = 4 * (INTERVAL + 1) + 2 + 4;
    n_checks++;
    if (td - ts - 1 != exp_len) begin
      n_errors++; $display("FAIL zw_run: got %0d busy cycles expected %0d", td - ts - 1, exp_len);
    end
    n_checks++;
    if ({pass_a[0], err_a[0]} !== {1'b1, 16'd0}) begin
      n_errors++; $display("FAIL zw_pass: got pass=%b err=%0d expected pass=1 err=0", pass_a[0], err_a[0]);
    end
  endtask

  task automatic test_reset_midrun;
    int ts, td, v;
    bit found;
    found = 0;
    start_a[0] = 1'b1;
    @(posedge clock); #1;
    start_a[0] = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      ack_a[0] = 1'b0;
      if (req_a[0]) begin
        if (addr_a[0] == BASE) ack_a[0] = 1'b1;
        else found = 1;
      end
      if (!found) begin @(posedge clock); #1; end
    end
    n_checks++;
    if (!found || wen_a[0] !== 1'b1) begin
      n_errors++; $display("FAIL mr_reach: got found=%0d wen=%b expected second write request", found, wen_a[0]);
    end
    ack_a[0] = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_checks++;
    if ({req_a[0], busy_a[0], done_a[0], err_a[0], first_a[0], addr_a[0]} !==
        {1'b0, 1'b0, 1'b0, 16'd0, 64'h0, BASE}) begin
      n_errors++; $display("FAIL mr_after: got req=%b busy=%b done=%b err=%0d first=%h addr=%h expected 0 0 0 0 0 %h",
                           req_a[0], busy_a[0], done_a[0], err_a[0], first_a[0], addr_a[0], BASE);
    end
    build_exp(2, 64'h0);
    drive_run(0, 2, 1'b0, -1, 0, 1'b0, ts, td, v);
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0] !== exp_q[0]) begin
      n_errors++; $display("FAIL mr_rerun: got %h expected %h", (obs_q.size() > 0) ? obs_q[0] : 193'h0, exp_q[0]);
    end
    n_checks++;
    if ({done_a[0], pass_a[0]} !== 2'b11) begin
      n_errors++; $display("FAIL mr_pass: got done=%b pass=%b expected 1 1", done_a[0], pass_a[0]);
    end
  endtask

  task automatic test_back_to_back;
    int ts, td, v;
    drive_run(0, 1, 1'b0, $urandom_range(0, NLINES - 1), $urandom_range(0, 127), 1'b0, ts, td, v);
    drive_run(0, 1, 1'b0, -1, 0, 1'b0, ts, td, v);
    n_checks++;
    if (rise_q.size() == 0 || rise_q[0] != ts + 1 + INTERVAL) begin
      n_errors++; $display("FAIL b2b_rise: got %0d expected %0d", (rise_q.size() > 0) ? rise_q[0] : -1, ts + 1 + INTERVAL);
    end
    n_checks++;
    if ({pass_a[0], err_a[0], first_a[0]} !== {1'b1, 16'd0, 64'h0}) begin
      n_errors++; $display("FAIL b2b_clear: got pass=%b err=%0d first=%h expected 1 0 0",
                           pass_a[0], err_a[0], first_a[0]);
    end
  endtask

  task automatic test_start_while_busy;
    int ts, td, v, me;
    logic [63:0] mf;
    build_exp(1, SEED_RO);
    drive_run(1, 2, 1'b0, -1, 0, 1'b1, ts, td, v);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL sb_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if ((obs_q[i] & HDR_MASK) !== (exp_q[i] & HDR_MASK)) begin
        n_errors++; $display("FAIL sb_req[%0d]: got %h expected %h", i, obs_q[i][192:128], exp_q[i][192:128]);
      end
    end
    n_checks++;
    if (rise_q.size() == 0 || rise_q[0] != ts + 1 + INTERVAL) begin
      n_errors++; $display("FAIL sb_rise: got %0d expected %0d", (rise_q.size() > 0) ? rise_q[0] : -1, ts + 1 + INTERVAL);
    end
    model_errs(SEED_RO, me, mf);
    n_checks++;
    if ({pass_a[1], err_a[1], first_a[1]} !== {1'b0, 16'(me), mf} || me != 2) begin
      n_errors++; $display("FAIL sb_result: got pass=%b err=%0d first=%h expected pass=0 err=%0d first=%h",
                           pass_a[1], err_a[1], first_a[1], me, mf);
    end
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({done_a[1], busy_a[1], req_a[1]} !== 3'b100) begin
      n_errors++; $display("FAIL sb_hold: got done=%b busy=%b req=%b expected 1 0 0", done_a[1], busy_a[1], req_a[1]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_a[d] = 1'b0;
      ack_a[d] = 1'b0;
      rdata_a[d] = '0;
    end
    test_reset;
    test_write_verify;
    test_interval;
    test_corruption;
    test_zero_wait;
    test_reset_midrun;
    test_back_to_back;
    test_start_while_busy;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
